// File: rtl/top.sv
// Sine demonstrator display: folds the button angle onto a quarter-wave
// table and scans sign/angle and sin(angle) onto two 7-segment banks.
module top #(
    parameter int SCAN_DIV = 4
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [7:0] buttons,
    output logic [7:0] LED_ENCODE1,
    output logic [7:0] LED_ENCODE2,
    output logic [7:0] LED_SELECT
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    // round(sin(i deg) * 1000), i = 0..90
    localparam logic [9:0] SIN_ROM [0:90] = '{
        10'd0,   10'd17,  10'd35,  10'd52,  10'd70,
        10'd87,  10'd105, 10'd122, 10'd139, 10'd156,
        10'd174, 10'd191, 10'd208, 10'd225, 10'd242,
        10'd259, 10'd276, 10'd292, 10'd309, 10'd326,
        10'd342, 10'd358, 10'd375, 10'd391, 10'd407,
        10'd423, 10'd438, 10'd454, 10'd469, 10'd485,
        10'd500, 10'd515, 10'd530, 10'd545, 10'd559,
        10'd574, 10'd588, 10'd602, 10'd616, 10'd629,
        10'd643, 10'd656, 10'd669, 10'd682, 10'd695,
        10'd707, 10'd719, 10'd731, 10'd743, 10'd755,
        10'd766, 10'd777, 10'd788, 10'd799, 10'd809,
        10'd819, 10'd829, 10'd839, 10'd848, 10'd857,
        10'd866, 10'd875, 10'd883, 10'd891, 10'd899,
        10'd906, 10'd914, 10'd921, 10'd927, 10'd934,
        10'd940, 10'd946, 10'd951, 10'd956, 10'd961,
        10'd966, 10'd970, 10'd974, 10'd978, 10'd982,
        10'd985, 10'd988, 10'd990, 10'd993, 10'd995,
        10'd996, 10'd998, 10'd999, 10'd999, 10'd1000,
        10'd1000
    };

    function automatic logic [7:0] glyph(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = 8'h3F;
            4'd1:    g = 8'h06;
            4'd2:    g = 8'h5B;
            4'd3:    g = 8'h4F;
            4'd4:    g = 8'h66;
            4'd5:    g = 8'h6D;
            4'd6:    g = 8'h7D;
            4'd7:    g = 8'h07;
            4'd8:    g = 8'h7F;
            4'd9:    g = 8'h6F;
            default: g = 8'h00;
        endcase
        return g;
    endfunction

    logic [DW-1:0] div_q;
    logic [1:0]    slot_q;
    logic [7:0]    ang_q;

    logic [6:0] idx;
    logic       neg_fold;
    logic [9:0] mag;
    logic [9:0] frac;
    logic       int_dig;
    logic       neg;
    logic [7:0] dig [0:7];

    always_comb begin
        idx      = ang_q[6:0];
        neg_fold = 1'b0;
        if (ang_q <= 8'd90) begin
            idx = ang_q[6:0];
        end else if (ang_q <= 8'd180) begin
            idx = 7'(8'd180 - ang_q);
        end else begin
            idx      = 7'(ang_q - 8'd180);
            neg_fold = 1'b1;
        end
    end

    assign mag     = (idx <= 7'd90) ? SIN_ROM[idx] : 10'd0;
    assign int_dig = (mag == 10'd1000);
    assign frac    = int_dig ? 10'd0 : mag;
    // sin(180) folds to zero: never show "-0.000"
    assign neg     = neg_fold && (mag != 10'd0);

    always_comb begin
        dig[7] = neg ? 8'h40 : 8'h00;
        dig[6] = glyph(4'(ang_q / 8'd100));
        dig[5] = glyph(4'((ang_q / 8'd10) % 8'd10));
        dig[4] = glyph(4'(ang_q % 8'd10));
        dig[3] = glyph({3'b000, int_dig}) | 8'h80;
        dig[2] = glyph(4'(frac / 10'd100));
        dig[1] = glyph(4'((frac / 10'd10) % 10'd10));
        dig[0] = glyph(4'(frac % 10'd10));
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            div_q       <= '0;
            slot_q      <= 2'd0;
            ang_q       <= 8'd0;
            LED_SELECT  <= 8'h00;
            LED_ENCODE1 <= 8'h00;
            LED_ENCODE2 <= 8'h00;
        end else begin
            ang_q <= buttons;
            if (div_q == DIV_LAST) begin
                div_q  <= '0;
                slot_q <= slot_q + 2'd1;
            end else begin
                div_q <= div_q + 1'b1;
            end
            // slot S drives digit 7-S on the left and 3-S on the right
            LED_SELECT  <= (8'h80 >> slot_q) | (8'h08 >> slot_q);
            LED_ENCODE1 <= dig[{1'b1, ~slot_q}];
            LED_ENCODE2 <= dig[{1'b0, ~slot_q}];
        end
    end

endmodule

// File: tb/tb_top.sv
// Bench for the sine display: reference model uses real-valued sin()
// and decimal arithmetic on the angle to predict every scanned glyph.
module tb_top;

    localparam int SD = 4;

    logic       CLK;
    logic       Reset;
    logic [7:0] buttons;
    logic [7:0] LED_ENCODE1;
    logic [7:0] LED_ENCODE2;
    logic [7:0] LED_SELECT;

    int n_pass;
    int n_total;
    int ncyc;

    logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    top #(.SCAN_DIV(SD)) dut (
        .CLK(CLK),
        .Reset(Reset),
        .buttons(buttons),
        .LED_ENCODE1(LED_ENCODE1),
        .LED_ENCODE2(LED_ENCODE2),
        .LED_SELECT(LED_SELECT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // edges since release; output after edge n is slot ((n-1)/SD)%4
    always @(posedge CLK) begin
        if (Reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;
    end

    function automatic real sin_deg(int a);
        return $sin(real'(a) * 3.141592653589793 / 180.0);
    endfunction

    function automatic int sin_mag(int a);
        real s;
        s = sin_deg(a);
        if (s < 0.0) s = -s;
        return $rtoi(s * 1000.0 + 0.5);
    endfunction

    function automatic logic [7:0] exp_digit(int a, int d);
        int m;
        bit neg;
        m   = sin_mag(a);
        neg = (sin_deg(a) < 0.0) && (m != 0);
        case (d)
            7: return neg ? 8'h40 : 8'h00;
            6: return seg_tab[a / 100];
            5: return seg_tab[(a / 10) % 10];
            4: return seg_tab[a % 10];
            3: return seg_tab[m / 1000] | 8'h80;
            2: return seg_tab[(m / 100) % 10];
            1: return seg_tab[(m / 10) % 10];
            default: return seg_tab[m % 10];
        endcase
    endfunction

    function automatic int exp_slot();
        return ((ncyc - 1) / SD) % 4;
    endfunction

    function automatic logic [7:0] exp_sel(int s);
        return (8'h80 >> s) | (8'h08 >> s);
    endfunction

    function automatic bit is_digit(logic [7:0] v);
        for (int i = 0; i < 10; i++)
            if (v == seg_tab[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit valid_left(logic [7:0] v, int s);
        if (s == 0) return (v == 8'h00) || (v == 8'h40);
        return is_digit(v);
    endfunction

    function automatic bit valid_right(logic [7:0] v, int s);
        if (s == 0) return v[7] && is_digit({1'b0, v[6:0]});
        return is_digit(v);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset   = 1'b1;
        buttons = 8'h3C;
        repeat (22) begin
            step();
            n_total++;
            if ({LED_SELECT, LED_ENCODE1, LED_ENCODE2} !== 24'h0)
                $display("FAIL reset_hold: got %h/%h/%h want 00/00/00",
                         LED_SELECT, LED_ENCODE1, LED_ENCODE2);
            else n_pass++;
        end
        Reset = 1'b0;
        step();
        n_total++;
        if (LED_SELECT !== 8'h88)
            $display("FAIL release_sel: got %h want 88", LED_SELECT);
        else n_pass++;
        n_total++;
        if (LED_ENCODE1 !== 8'h00)
            $display("FAIL release_e1: got %h want 00", LED_ENCODE1);
        else n_pass++;
        n_total++;
        if (LED_ENCODE2 !== 8'hBF)
            $display("FAIL release_e2: got %h want BF", LED_ENCODE2);
        else n_pass++;
    endtask

    task automatic test_frame();
        int s;
        repeat (4 * SD) begin
            step();
            s = exp_slot();
            n_total++;
            if (LED_SELECT !== exp_sel(s))
                $display("FAIL frame_sel: got %h want %h", LED_SELECT, exp_sel(s));
            else n_pass++;
            n_total++;
            if (LED_ENCODE1 !== exp_digit(60, 7 - s))
                $display("FAIL frame_e1: slot %0d got %h want %h",
                         s, LED_ENCODE1, exp_digit(60, 7 - s));
            else n_pass++;
            n_total++;
            if (LED_ENCODE2 !== exp_digit(60, 3 - s))
                $display("FAIL frame_e2: slot %0d got %h want %h",
                         s, LED_ENCODE2, exp_digit(60, 3 - s));
            else n_pass++;
        end
    endtask

    task automatic test_boundaries();
        int tbl [6] = '{90, 210, 0, 180, 255, 75};
        int s;
        foreach (tbl[k]) begin
            buttons = 8'(tbl[k]);
            repeat (4) begin
                step();
                s = exp_slot();
                n_total++;
                if (LED_SELECT !== exp_sel(s))
                    $display("FAIL bnd_lat_sel: got %h want %h",
                             LED_SELECT, exp_sel(s));
                else n_pass++;
            end
            repeat (4 * SD) begin
                step();
                s = exp_slot();
                n_total++;
                if (LED_SELECT !== exp_sel(s))
                    $display("FAIL bnd_sel: got %h want %h",
                             LED_SELECT, exp_sel(s));
                else n_pass++;
                n_total++;
                if (LED_ENCODE1 !== exp_digit(tbl[k], 7 - s))
                    $display("FAIL bnd_e1: a=%0d slot %0d got %h want %h", tbl[k],
                             s, LED_ENCODE1, exp_digit(tbl[k], 7 - s));
                else n_pass++;
                n_total++;
                if (LED_ENCODE2 !== exp_digit(tbl[k], 3 - s))
                    $display("FAIL bnd_e2: a=%0d slot %0d got %h want %h", tbl[k],
                             s, LED_ENCODE2, exp_digit(tbl[k], 3 - s));
                else n_pass++;
            end
        end
    endtask

    task automatic test_sweep();
        int order [256];
        int j;
        int t;
        int s;
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 256; i++) begin
            buttons = 8'(order[i]);
            repeat ($urandom_range(4, 6)) step();
            repeat (4 * SD) begin
                step();
                s = exp_slot();
                n_total++;
                if (LED_ENCODE1 !== exp_digit(order[i], 7 - s))
                    $display("FAIL sweep_e1: a=%0d slot %0d got %h want %h", order[i],
                             s, LED_ENCODE1, exp_digit(order[i], 7 - s));
                else n_pass++;
                n_total++;
                if (LED_ENCODE2 !== exp_digit(order[i], 3 - s))
                    $display("FAIL sweep_e2: a=%0d slot %0d got %h want %h", order[i],
                             s, LED_ENCODE2, exp_digit(order[i], 3 - s));
                else n_pass++;
            end
        end
    endtask

    task automatic test_churn();
        int s;
        repeat (200) begin
            buttons = 8'($urandom);
            step();
            s = exp_slot();
            n_total++;
            if (LED_SELECT !== exp_sel(s))
                $display("FAIL churn_sel: got %h want %h", LED_SELECT, exp_sel(s));
            else n_pass++;
            n_total++;
            if (!valid_left(LED_ENCODE1, s))
                $display("FAIL churn_e1: slot %0d got %h want valid glyph",
                         s, LED_ENCODE1);
            else n_pass++;
            n_total++;
            if (!valid_right(LED_ENCODE2, s))
                $display("FAIL churn_e2: slot %0d got %h want valid glyph",
                         s, LED_ENCODE2);
            else n_pass++;
        end
    endtask

    task automatic test_midreset();
        int k;
        int s;
        buttons = 8'hFF;
        k = 0;
        step();
        while (exp_slot() != 2 && k < 32) begin
            step();
            k++;
        end
        n_total++;
        if (k >= 32) $display("FAIL mid_wait: got timeout want slot 2");
        else n_pass++;
        Reset = 1'b1;
        repeat (10) begin
            step();
            n_total++;
            if ({LED_SELECT, LED_ENCODE1, LED_ENCODE2} !== 24'h0)
                $display("FAIL mid_hold: got %h/%h/%h want 00/00/00",
                         LED_SELECT, LED_ENCODE1, LED_ENCODE2);
            else n_pass++;
        end
        Reset = 1'b0;
        step();
        n_total++;
        if (LED_SELECT !== 8'h88)
            $display("FAIL mid_release_sel: got %h want 88", LED_SELECT);
        else n_pass++;
        n_total++;
        if (!valid_left(LED_ENCODE1, 0) || !valid_right(LED_ENCODE2, 0))
            $display("FAIL mid_release_glyph: got %h/%h want valid glyphs",
                     LED_ENCODE1, LED_ENCODE2);
        else n_pass++;
        repeat (3) step();
        repeat (4 * SD) begin
            step();
            s = exp_slot();
            n_total++;
            if (LED_SELECT !== exp_sel(s))
                $display("FAIL mid_sel: got %h want %h", LED_SELECT, exp_sel(s));
            else n_pass++;
            n_total++;
            if (LED_ENCODE1 !== exp_digit(255, 7 - s) ||
                LED_ENCODE2 !== exp_digit(255, 3 - s))
                $display("FAIL mid_digits: slot %0d got %h/%h want %h/%h", s,
                         LED_ENCODE1, LED_ENCODE2,
                         exp_digit(255, 7 - s), exp_digit(255, 3 - s));
            else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        Reset   = 1'b1;
        buttons = 8'h3C;
        test_reset();
        test_frame();
        test_boundaries();
        test_sweep();
        test_churn();
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/top.md
# top

Top-level display block of the sine demonstrator. Samples an 8-bit angle (degrees) from the board buttons, computes sin(angle) from a quarter-wave lookup table, and drives two 4-digit multiplexed 7-segment banks. Left bank shows sign and angle; right bank shows sin to three decimals. Sits directly under the board pin constraints; no submodule is visible outside it.

## Interface

- SCAN_DIV, default 4: clocks per scan slot. Use 4 for simulation, about 100000 on the board.
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- buttons  input  8  unsigned angle in degrees, 0..255.
- LED_ENCODE1  output  8  left-bank segments, active-high. Bit order [0]=a … [6]=g, [7]=dp.
- LED_ENCODE2  output  8  right-bank segments, same encoding.
- LED_SELECT  output  8  digit enables, active-high. Bit 7 is the leftmost digit overall, bit 0 the rightmost. Bits [7:4] belong to the left bank, bits [3:0] to the right bank.

## Operation

- Angle register A ← buttons every cycle.
- Quarter-wave fold of A:
  - A ≤ 90: idx = A, positive.
  - 91 ≤ A ≤ 180: idx = 180−A, positive.
  - A ≥ 181: idx = A−180, negative.
- ROM has 91 entries: M = round(sin(idx°)×1000), range 0..1000 (e.g. idx 30→500, 60→866, 75→966, 90→1000).
- NEG = negative fold AND M≠0.
- BCD conversion:
  - M → I (0/1) and fraction digits F2 F1 F0.
  - A → hundreds, tens, units (H T U).
  - Any method is allowed provided it meets the latency in Timing.
- Digit contents:
  - 7 = '-' if NEG, else blank.
  - 6 = H, 5 = T, 4 = U (leading zeros shown).
  - 3 = I with dp lit.
  - 2 = F2, 1 = F1, 0 = F0.
- Glyphs (without dp):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - '-'=40, blank=00.
  - dp adds bit 7 (80).
- Scan:
  - Divider counts 0..SCAN_DIV−1.
  - On wrap, slot index S increments mod 4.
  - In slot S: LED_SELECT has bits (7−S) and (3−S) set. LED_ENCODE1 shows digit 7−S; LED_ENCODE2 shows digit 3−S.
- All three outputs are registered.

## Timing

- Reset (synchronous):
  - Divider=0, S=0, A=0.
  - Outputs LED_SELECT=00, LED_ENCODE1=00, LED_ENCODE2=00 on the edge where Reset is sampled high, and held while Reset stays high.
- First edge with Reset low:
  - Outputs show slot 0: LED_SELECT=88, digits 7 and 3.
  - Each slot lasts exactly SCAN_DIV cycles.
  - Full frame is 4×SCAN_DIV cycles; order 88→44→22→11→88.
- Latency: a buttons change is reflected in the output registers no more than 4 cycles after the change, in whatever slot is then current.
  - Intermediate cycles may show old or new digits.
  - Digits never show non-glyph codes.
- Reset asserted mid-frame: scan restarts at slot 0 and the computed value is recomputed from buttons after release. No stale glyph appears after the latency window.
- Buttons changing every cycle: the display must still only ever show valid glyphs.
- Boundaries:
  - A=0 and A=180: display "0.000", not negative.
  - A=90: display "1.000".
  - A=255: display "-0.966".

## Test plan

- Reset sequence: buttons=3C, Reset high for 22 cycles → all outputs 00 during reset. First edge after release: LED_SELECT=88, LED_ENCODE1=00, LED_ENCODE2=BF.
- Full frame, buttons=3C, SCAN_DIV=4:
  - LED_SELECT=88: E1=00, E2=BF.
  - LED_SELECT=44: E1=3F, E2=7F.
  - LED_SELECT=22: E1=7D, E2=7D.
  - LED_SELECT=11: E1=3F, E2=7D.
  - Each slot holds 4 cycles.
- buttons=5A (90) → right bank "1.000". Digit 3 = 86, digits 2..0 = 3F. Left digit 7 blank; left digits 6,5,4 = 3F,6F,3F ("090").
- buttons=D2 (210) → left digit 7 = 40 ('-'), left digits 6,5,4 = "210". Right bank "0.500": BF, 6D, 3F, 3F.
- buttons=00 and B4 (180) → right bank BF,3F,3F,3F; left digit 7 = 00. Then buttons=FF → '-' and "0.966" within 4 cycles plus one frame.
- Reset pulse of 10 cycles mid-frame while in slot 2 → outputs 00 during reset, then slot 0 (LED_SELECT=88) on the first edge after release.
